// File: rtl/uart_pkg.sv
// Shared UART types, parity modes and the parity helper used by the RX monitor
// and any future TX block.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Expected parity bit for up to 9 data bits; unused upper bits must be zero.
    function automatic logic uart_parity(input logic [8:0] data, input int mode);
        logic p;
        case (mode)
            PARITY_ODD:  p = ~^data;
            PARITY_EVEN: p = ^data;
            default:     p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word (first-word-fall-through).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_nxt;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_nxt  = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // The head register follows the oldest entry; it holds when the FIFO drains.
            if (pop_ok) begin
                if (count > CW'(1)) begin
                    rdata <= mem[rd_nxt];
                end else if (push_ok) begin
                    rdata <= wdata;
                end
            end else if (empty && push_ok) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/uart_rx_mon.sv
// Oversampling UART receiver with mid-bit sampling, parity and stop-bit checks,
// sticky line-error flags and a receive FIFO.
module uart_rx_mon
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 868,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    output logic [DATA_BITS-1:0]          rdata,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          err_clr,
    output uart_rx_state_t                dbg_state
);

    // Read side: a byte is consumed on every cycle where rvalid && rready;
    // rdata is stable while rvalid is high and not popped.

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_d;

    uart_rx_state_t         state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [IDX_W-1:0]       bit_idx, bit_idx_n;
    logic                   stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   par_bad, par_bad_n;
    logic                   push;
    logic                   set_ferr;
    logic                   set_perr;
    logic                   set_ovf;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxs_d  <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bad  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            stop_idx <= stop_idx_n;
            shreg    <= shreg_n;
            par_bad  <= par_bad_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        par_bad_n  = par_bad;
        push       = 1'b0;
        set_ferr   = 1'b0;
        set_perr   = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt == '0) begin
                    // A start bit that is high again at its centre is a glitch.
                    if (!rxs) begin
                        state_n   = DATA;
                        cnt_n     = FULL_LOAD;
                        bit_idx_n = '0;
                        par_bad_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_n[bit_idx] = rxs;
                    cnt_n            = FULL_LOAD;
                    if (bit_idx == LAST_IDX) begin
                        stop_idx_n = 1'b0;
                        state_n    = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PARITY: begin
                if (cnt == '0) begin
                    par_bad_n = (rxs != uart_parity(9'(shreg), PARITY_MODE));
                    cnt_n     = FULL_LOAD;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        set_ferr = 1'b1;
                        state_n  = WAIT_IDLE;
                    end else if (stop_idx == LAST_STOP) begin
                        set_perr = par_bad;
                        push     = !par_bad;
                        state_n  = IDLE;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                        cnt_n      = FULL_LOAD;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line is released so a break cannot start a frame.
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign pop     = rvalid && rready;
    assign set_ovf = push && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err  <= set_ferr ? 1'b1 : (err_clr ? 1'b0 : frame_err);
            parity_err <= set_perr ? 1'b1 : (err_clr ? 1'b0 : parity_err);
            overflow   <= set_ovf  ? 1'b1 : (err_clr ? 1'b0 : overflow);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rvalid    = !fifo_empty;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_mon.sv
// Bench for uart_rx_mon: an 8N1 instance and an 8E1 instance, both 4-deep,
// driven with directed frames, a vector table and random frames against a frame-level model.
module tb_uart_rx_mon;
    import uart_pkg::*;

    localparam int CLK_DIV = 8;
    localparam int DEPTH   = 4;
    // Clocks from the start-bit falling edge to the stop-bit decision edge.
    localparam int DECIDE  = 9 * CLK_DIV + CLK_DIV / 2 + 2;

    logic           clk;
    logic           rst;
    logic           rxd        [2];
    logic           rready     [2];
    logic           err_clr    [2];
    logic [7:0]     rdata      [2];
    logic           rvalid     [2];
    logic [2:0]     fifo_count [2];
    logic           busy       [2];
    logic           frame_err  [2];
    logic           parity_err [2];
    logic           overflow   [2];
    uart_rx_state_t dbg_state  [2];

    int vectors;
    int miscompares;
    logic [7:0] exp_q[$];
    bit m_perr, m_ferr, m_ovf;

    typedef struct {
        logic [7:0] data;
        bit         par_flip;
        bit         stop_v;
        bit         clr_before;
        int         exp_count;
        bit         exp_perr;
        bit         exp_ferr;
        bit         exp_ovf;
    } vec_t;
    vec_t tbl[8];

    uart_rx_mon #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
    ) u_n (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
        .rready(rready[0]), .fifo_count(fifo_count[0]), .busy(busy[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overflow(overflow[0]),
        .err_clr(err_clr[0]), .dbg_state(dbg_state[0])
    );

    uart_rx_mon #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_MODE(PARITY_EVEN),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
    ) u_e (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
        .rready(rready[1]), .fifo_count(fifo_count[1]), .busy(busy[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overflow(overflow[1]),
        .err_clr(err_clr[1]), .dbg_state(dbg_state[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_flags(input int w, input string name, input bit p, input bit f, input bit o);
        check({name, "_perr"}, parity_err[w], p);
        check({name, "_ferr"}, frame_err[w], f);
        check({name, "_ovf"}, overflow[w], o);
    endtask

    task automatic check_reset_outputs(input int w, input string name);
        check({name, "_rvalid"}, rvalid[w], 0);
        check({name, "_rdata"}, rdata[w], 0);
        check({name, "_count"}, fifo_count[w], 0);
        check({name, "_busy"}, busy[w], 0);
        check_flags(w, name, 0, 0, 0);
    endtask

    // driver tasks
    task automatic send_frame(input int w, input logic [7:0] d, input bit par_flip,
                              input bit stop_v, input int tail_low);
        @(negedge clk);
        rxd[w] = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd[w] = d[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        if (w == 1) begin
            rxd[w] = (^d) ^ par_flip;
            repeat (CLK_DIV) @(negedge clk);
        end
        rxd[w] = stop_v;
        repeat (CLK_DIV + tail_low) @(negedge clk);
        rxd[w] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One-cycle pulse of rready or err_clr timed onto the stop decision of an 8N1 frame.
    task automatic pulse_at_decide(input int w, input bit is_clr);
        @(negedge clk);
        repeat (DECIDE) @(negedge clk);
        if (is_clr) err_clr[w] = 1'b1;
        else        rready[w]  = 1'b1;
        @(negedge clk);
        err_clr[w] = 1'b0;
        rready[w]  = 1'b0;
    endtask

    task automatic clr(input int w);
        @(negedge clk);
        err_clr[w] = 1'b1;
        @(negedge clk);
        err_clr[w] = 1'b0;
        if (w == 1) begin
            m_perr = 0;
            m_ferr = 0;
            m_ovf  = 0;
        end
    endtask

    task automatic read_one(input int w, input logic [7:0] exp, input string name);
        check({name, "_rvalid"}, rvalid[w], 1);
        check({name, "_rdata"}, rdata[w], exp);
        rready[w] = 1'b1;
        @(negedge clk);
        rready[w] = 1'b0;
    endtask

    // scoreboard: frame-level model of the 8E1 instance
    task automatic model_frame(input logic [7:0] d, input bit pf, input bit sv);
        if (!sv)                         m_ferr = 1;
        else if (pf)                     m_perr = 1;
        else if (exp_q.size() < DEPTH)   exp_q.push_back(d);
        else                             m_ovf = 1;
    endtask

    task automatic pop_check(input string name);
        if (exp_q.size() == 0) begin
            check({name, "_empty"}, rvalid[1], 0);
        end else begin
            read_one(1, exp_q.pop_front(), name);
        end
    endtask

    task automatic check_model(input string name);
        check({name, "_count"}, fifo_count[1], exp_q.size());
        check_flags(1, name, m_perr, m_ferr, m_ovf);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_perr = 0; m_ferr = 0; m_ovf = 0;
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            rxd[w] = 1'b1; rready[w] = 1'b0; err_clr[w] = 1'b0;
        end

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h12, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1};

        repeat (4) @(negedge clk);
        check_reset_outputs(0, "rst_n");
        check_reset_outputs(1, "rst_e");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 basic receive
        send_frame(0, 8'h48, 0, 1, 0);
        send_frame(0, 8'h69, 0, 1, 0);
        check("t1_count", fifo_count[0], 2);
        read_one(0, 8'h48, "t1_rd0");
        read_one(0, 8'h69, "t1_rd1");
        check("t1_count_after", fifo_count[0], 0);
        check_flags(0, "t1", 0, 0, 0);

        // short low glitch
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (3) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy", busy[0], 0);
        check("glitch_count", fifo_count[0], 0);
        check_flags(0, "glitch", 0, 0, 0);

        // bad stop bit followed by a held-low break
        send_frame(0, 8'h55, 0, 0, 40);
        check("brk_count", fifo_count[0], 0);
        check("brk_busy", busy[0], 0);
        send_frame(0, 8'h33, 0, 1, 0);
        check_flags(0, "brk", 0, 1, 0);
        check("brk_count2", fifo_count[0], 1);
        read_one(0, 8'h33, "brk_rd");
        clr(0);
        check_flags(0, "brk_clr", 0, 0, 0);

        // overflow with depth 4
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 1, 0);
        check("ovf_count", fifo_count[0], 4);
        check_flags(0, "ovf", 0, 0, 1);
        for (int i = 1; i <= 4; i++) read_one(0, 8'(i), "ovf_rd");
        check("ovf_rvalid", rvalid[0], 0);
        check("ovf_hold", rdata[0], 8'h04);
        clr(0);
        check_flags(0, "ovf_clr", 0, 0, 0);

        // pop on the same cycle as a push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(0, 8'h11 + 8'(i), 0, 1, 0);
        fork
            send_frame(0, 8'h15, 0, 1, 0);
            pulse_at_decide(0, 1'b0);
        join
        check("pp_count", fifo_count[0], 4);
        check("pp_ovf", overflow[0], 0);
        for (int i = 0; i < 4; i++) read_one(0, 8'h12 + 8'(i), "pp_rd");

        // a set coinciding with err_clr keeps the flag
        fork
            send_frame(0, 8'h55, 0, 0, 0);
            pulse_at_decide(0, 1'b1);
        join
        check("clrwin_ferr", frame_err[0], 1);

        // 8E1 table
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].clr_before) clr(1);
            send_frame(1, tbl[i].data, tbl[i].par_flip, tbl[i].stop_v, 0);
            model_frame(tbl[i].data, tbl[i].par_flip, tbl[i].stop_v);
            check($sformatf("tbl%0d_count", i), fifo_count[1], tbl[i].exp_count);
            check_flags(1, $sformatf("tbl%0d", i), tbl[i].exp_perr, tbl[i].exp_ferr, tbl[i].exp_ovf);
        end
        for (int i = 0; i < 4; i++) pop_check("tbl_drain");
        check("tbl_rvalid", rvalid[1], 0);
        check("tbl_hold", rdata[1], 8'h80);

        // random frames against the model
        clr(1);
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit pf, sv;
            int npop;
            d  = 8'($urandom_range(0, 255));
            pf = ($urandom_range(0, 5) == 0);
            sv = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 4) == 0) clr(1);
            send_frame(1, d, pf, sv, 0);
            model_frame(d, pf, sv);
            check_model($sformatf("rnd%0d", i));
            npop = $urandom_range(0, 1);
            for (int k = 0; k < npop; k++) pop_check($sformatf("rnd%0d_rd", i));
        end

        // reset in the middle of a frame
        send_frame(0, 8'h5A, 0, 1, 0);
        @(negedge clk);
        rxd[0] = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("mid_busy", busy[0], 1);
        rxd[0] = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "mid_rst_n");
        check_reset_outputs(1, "mid_rst_e");
        exp_q.delete();
        m_perr = 0; m_ferr = 0; m_ovf = 0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(0, 8'h7E, 0, 1, 0);
        check("post_count", fifo_count[0], 1);
        read_one(0, 8'h7E, "post_rd");
        check("post_count2", fifo_count[0], 0);
        send_frame(1, 8'hC3, 0, 1, 0);
        model_frame(8'hC3, 0, 1);
        check_model("post_e");
        pop_check("post_e_rd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_mon.md
Name: uart_rx_mon

Overview:
Parametrised UART receiver with an output FIFO. It oversamples a serial line, reassembles frames with a configurable format, flags line errors, and buffers received bytes behind a valid/ready interface. It serves as the bench-side console sink for core_top's txd and can be reused in-core as a UART RX front end. It supersedes the ad-hoc start-bit/bit-delay loops in bench tops, adding mid-bit sampling, parity, stop-bit checking and buffering.

Parameters:
CLK_DIV, 868, clock cycles per bit (SYS_FREQ/UART_BAUD); must be >= 4
DATA_BITS, 8, data bits per frame, range 5..9, LSB first
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, receive FIFO entries, power of two, >= 2
SYNC_STAGES, 2, rxd synchroniser flops, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst=0 resets on rising clk)
rxd  in  1  asynchronous serial input, idle high
rdata  out  DATA_BITS  FIFO head byte
rvalid  out  1  FIFO non-empty
rready  in  1  consumer pop; a pop occurs when rvalid && rready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
busy  out  1  FSM not in IDLE
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch
overflow  out  1  sticky: completed frame dropped because FIFO full
err_clr  in  1  clears all sticky flags

Behaviour:
- Reset: FSM=IDLE, baud counter=0, FIFO empty; rvalid=0, rdata=0, fifo_count=0, busy=0, all sticky flags 0; synchroniser flops preset to 1.
- rxd passes through SYNC_STAGES flops; every FSM decision uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: a 1->0 transition on rxs moves to START and loads the counter with CLK_DIV/2 - 1 (integer division).
- START: when the counter reaches 0, sample rxs. If 0: reload CLK_DIV-1, bit index=0, go to DATA. If 1 (glitch): return to IDLE and set no flag.
- DATA: on each counter expiry, shift the sample into bit[index]. After DATA_BITS samples, go to PARITY if PARITY_MODE!=0, else to STOP.
- PARITY: sample once. Expected bit is even: ^data; odd: ~^data. A mismatch latches a frame-local error.
- STOP: sample STOP_BITS times at CLK_DIV spacing.
  - Any stop sample 0: set frame_err, discard the frame, go to WAIT_IDLE.
  - Otherwise, with a parity error: set parity_err, discard the frame, go to IDLE.
  - Otherwise: push the frame and go to IDLE.
  - The push happens on the cycle of the last stop sample.
- WAIT_IDLE: stay until rxs=1 (break or line held low), then go to IDLE. This prevents false starts inside a break.
- Timing: all samples are at bit centres, i.e. CLK_DIV/2 + k*CLK_DIV cycles after the detected falling edge (plus synchroniser latency). The next start bit can be detected on the cycle after returning to IDLE.
- FIFO behaviour:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rdata is registered-head (first-word-fall-through); it updates the cycle after the push that makes the FIFO non-empty.
  - rdata holds its value when empty.
- Sticky flags: err_clr clears them. A set in the same cycle as err_clr wins, so the flag stays 1.
- Reset mid-frame aborts the frame immediately and flushes the FIFO.
- DATA_BITS=9 with parity is legal (12-bit frame minimum).

Decomposition:
- Shared package uart_pkg holds:
  - enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}
  - localparams PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2
  - function uart_parity(data, mode)
- One sub-module: sync_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count), reusable for a future TX block.

Test Plan:
1. CLK_DIV=8, 8N1, rxd sends 0x48 then 0x69 -> rvalid rises; with rready=1, reads return 0x48, 0x69; no flags set.
2. 8E1, send 0xA5 with correct parity bit 0, then 0xA5 with parity bit 1 -> first byte is pushed; second is discarded and parity_err=1; fifo_count=1.
3. Stop bit forced 0 on 0x55, line held low 40 cycles, then 0x33 sent normally -> frame_err=1, 0x55 dropped, no spurious byte during the break, 0x33 received.
4. rxd low pulse of 3 cycles (< CLK_DIV/2) -> FSM returns to IDLE, no push, no flags.
5. FIFO_DEPTH=4, rready=0, send 5 bytes 0x01..0x05 -> fifo_count=4, overflow=1, reads give 0x01..0x04. Next: pop on the same cycle as a push when full -> count stays 4, no overflow. Then err_clr -> overflow=0.
6. Assert rst=0 during DATA of a frame, release, send 0x7E -> FIFO empty after reset, only 0x7E received, all outputs are at reset values during reset.
